bubble_sort_engine: RTL and testbench

Hand-written callee for the method-call handshake used by the compiler-generated modules: it owns a small unsigned array, exposes a load/read port, and performs an in-place ascending bubble sort when its `run` method is called. It sits behind a caller (a generated module or a simulation top) that drives `run_req` and waits on `run_busy`. The block is the responder side of that req/busy/return protocol. It is also the hardware reference for sort benchmarks.

---
 rtl/bubble_sort_engine.sv | 170 +++++++++++++++++
 tb/tb_bubble_sort_engine.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bubble_sort_engine.sv
// bubble_sort_engine
// Responder side of the req/busy/return method-call handshake. Owns a
// DEPTH x WIDTH unsigned array with a load/read port and, when the run
// method is called, sorts it in place (ascending bubble sort with early
// exit). run_return carries the swap count of the last completed call.
//
// Handshake: the caller raises run_req; it is level-sampled only while
// idle. run_busy rises the cycle after acceptance and stays high until the
// edge that also updates run_return. Requests seen while busy are ignored,
// and a request held high restarts the method after one idle cycle.
module bubble_sort_engine #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              data_we,
    input  logic [WIDTH-1:0]  data_din,
    output logic [WIDTH-1:0]  data_dout,
    input  logic              run_req,
    output logic              run_busy,
    output logic [15:0]       run_return,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE_S    = 2'd0,
        COMPARE_S = 2'd1,
        SWAP_S    = 2'd2,
        DONE_S    = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LIMIT_C = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_C   = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] limit_q, limit_d;
    logic              swapped_q, swapped_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       ret_q, ret_d;
    logic              busy_q, busy_d;
    logic [WIDTH-1:0]  dout_q;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic [ADDR_W-1:0] idx_inc;
    logic [WIDTH-1:0]  a_lo;
    logic [WIDTH-1:0]  a_hi;
    logic              pass_more;
    logic              do_swap;
    logic              addr_ok;

    assign idx_inc   = idx_q + ONE_C;
    assign a_lo      = mem_q[idx_q];
    assign a_hi      = mem_q[idx_inc];
    assign pass_more = (idx_inc < limit_q);
    assign addr_ok   = ({1'b0, data_addr} < DEPTH_C);

    assign data_dout   = dout_q;
    assign run_busy    = busy_q;
    assign run_return  = ret_q;
    assign dbg_state_o = state_q;

    // Next-state and datapath control for the sort sequencer.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        limit_d   = limit_q;
        swapped_d = swapped_q;
        count_d   = count_q;
        ret_d     = ret_q;
        do_swap   = 1'b0;
        case (state_q)
            IDLE_S: begin
                if (run_req) begin
                    state_d   = COMPARE_S;
                    idx_d     = '0;
                    limit_d   = LIMIT_C;
                    swapped_d = 1'b0;
                    count_d   = '0;
                end
            end
            COMPARE_S: begin
                if (a_lo > a_hi) begin
                    state_d = SWAP_S;
                end else if (pass_more) begin
                    idx_d = idx_inc;
                end else if (!swapped_q || limit_q == ONE_C) begin
                    state_d = DONE_S;
                end else begin
                    limit_d   = limit_q - ONE_C;
                    idx_d     = '0;
                    swapped_d = 1'b0;
                end
            end
            SWAP_S: begin
                // This pass has swapped, so it can only end early on limit 1.
                do_swap   = 1'b1;
                swapped_d = 1'b1;
                if (count_q != 16'hFFFF) begin
                    count_d = count_q + 16'd1;
                end
                if (pass_more) begin
                    state_d = COMPARE_S;
                    idx_d   = idx_inc;
                end else if (limit_q == ONE_C) begin
                    state_d = DONE_S;
                end else begin
                    state_d   = COMPARE_S;
                    limit_d   = limit_q - ONE_C;
                    idx_d     = '0;
                    swapped_d = 1'b0;
                end
            end
            DONE_S: begin
                ret_d   = count_q;
                state_d = IDLE_S;
            end
            default: begin
                state_d = IDLE_S;
            end
        endcase
    end

    assign busy_d = (state_d != IDLE_S);

    // Control state registers; reset abandons any call in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE_S;
            idx_q     <= '0;
            limit_q   <= '0;
            swapped_q <= 1'b0;
            count_q   <= '0;
            ret_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            limit_q   <= limit_d;
            swapped_q <= swapped_d;
            count_q   <= count_d;
            ret_q     <= ret_d;
            busy_q    <= busy_d;
        end
    end

    // Array storage: swap pair while sorting, external writes only when idle,
    // and a registered read that returns pre-write contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            dout_q <= '0;
        end else begin
            if (do_swap) begin
                mem_q[idx_q]   <= a_hi;
                mem_q[idx_inc] <= a_lo;
            end else if (!busy_q && data_we && addr_ok) begin
                mem_q[data_addr] <= data_din;
            end
            dout_q <= addr_ok ? mem_q[data_addr] : '0;
        end
    end

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Directed bench for bubble_sort_engine: reset, reverse/sorted/duplicate
// sorts, read-during-write, held-request protocol and reset mid-sort.
module tb_bubble_sort_engine;

    localparam int DEPTH  = 16;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 4;
    localparam int BOUND  = 2000;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] data_addr = '0;
    logic              data_we = 1'b0;
    logic [WIDTH-1:0]  data_din = '0;
    logic [WIDTH-1:0]  data_dout;
    logic              run_req = 1'b0;
    logic              run_busy;
    logic [15:0]       run_return;
    logic [1:0]        dbg_state;

    int vectors = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] stim [DEPTH];
    logic [WIDTH-1:0] exp_mem [DEPTH];

    bubble_sort_engine #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_addr  (data_addr),
        .data_we    (data_we),
        .data_din   (data_din),
        .data_dout  (data_dout),
        .run_req    (run_req),
        .run_busy   (run_busy),
        .run_return (run_return),
        .dbg_state_o(dbg_state)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Driver: write stim[] into the array through the load port.
    task automatic load_stim();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            data_addr = ADDR_W'(i);
            data_din  = stim[i];
            data_we   = 1'b1;
        end
        @(negedge clk);
        data_we = 1'b0;
    endtask

    // Driver: registered read of one address.
    task automatic read_word(input int a, output logic [WIDTH-1:0] v);
        @(negedge clk);
        data_addr = ADDR_W'(a);
        @(negedge clk);
        v = data_dout;
    endtask

    // Driver: one-cycle request pulse; returns at the first busy cycle.
    task automatic start_call();
        @(negedge clk);
        run_req = 1'b1;
        @(negedge clk);
        run_req = 1'b0;
    endtask

    // Driver: count busy cycles until idle, bounded.
    task automatic wait_idle(output int cycles, output bit timed_out);
        cycles = 0;
        timed_out = 1'b0;
        while (run_busy === 1'b1) begin
            cycles++;
            if (cycles > BOUND) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] v;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (run_busy !== 1'b0) begin
            $display("FAIL reset_busy got %0b want 0", run_busy); miscompares++;
        end
        vectors++;
        if (run_return !== 16'd0) begin
            $display("FAIL reset_return got %0d want 0", run_return); miscompares++;
        end
        vectors++;
        if (dbg_state !== 2'd0) begin
            $display("FAIL reset_state got %0d want 0", dbg_state); miscompares++;
        end
        for (int i = 0; i < DEPTH; i++) begin
            read_word(i, v);
            vectors++;
            if (v !== '0) begin
                $display("FAIL reset_mem[%0d] got %0h want 0", i, v); miscompares++;
            end
        end
    endtask

    task automatic test_reverse();
        int cyc;
        bit to;
        logic [WIDTH-1:0] v;
        for (int i = 0; i < DEPTH; i++) stim[i] = WIDTH'(DEPTH - i);
        load_stim();
        start_call();
        wait_idle(cyc, to);
        vectors++;
        if (to || cyc != 241) begin
            $display("FAIL reverse_busy got %0d cycles (timeout=%0d) want 241", cyc, to);
            miscompares++;
        end
        vectors++;
        if (run_return !== 16'd120) begin
            $display("FAIL reverse_return got %0d want 120", run_return); miscompares++;
        end
        for (int i = 0; i < DEPTH; i++) begin
            read_word(i, v);
            vectors++;
            if (v !== WIDTH'(i + 1)) begin
                $display("FAIL reverse_mem[%0d] got %0d want %0d", i, v, i + 1); miscompares++;
            end
        end
    endtask

    task automatic test_sorted();
        int cyc;
        bit to;
        logic [WIDTH-1:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            stim[i] = WIDTH'(i);
            exp_mem[i] = WIDTH'(i);
        end
        load_stim();
        start_call();
        wait_idle(cyc, to);
        vectors++;
        if (to || cyc != 16) begin
            $display("FAIL sorted_busy got %0d cycles (timeout=%0d) want 16", cyc, to);
            miscompares++;
        end
        vectors++;
        if (run_return !== 16'd0) begin
            $display("FAIL sorted_return got %0d want 0", run_return); miscompares++;
        end
        for (int i = 0; i < DEPTH; i++) begin
            read_word(i, v);
            vectors++;
            if (v !== exp_mem[i]) begin
                $display("FAIL sorted_mem[%0d] got %0d want %0d", i, v, exp_mem[i]); miscompares++;
            end
        end
    endtask

    task automatic test_rw_same_cycle();
        logic [WIDTH-1:0] v;
        @(negedge clk);
        data_addr = 4'd3;
        data_din  = 32'h1234_5678;
        data_we   = 1'b1;
        @(negedge clk);
        data_we = 1'b0;
        vectors++;
        if (data_dout !== exp_mem[3]) begin
            $display("FAIL rw_old got %0h want %0h", data_dout, exp_mem[3]); miscompares++;
        end
        read_word(3, v);
        vectors++;
        if (v !== 32'h1234_5678) begin
            $display("FAIL rw_new got %0h want 12345678", v); miscompares++;
        end
    endtask

    task automatic test_duplicates();
        logic [WIDTH-1:0] m [DEPTH];
        logic [WIDTH-1:0] t;
        logic [WIDTH-1:0] v;
        int inv, comps, swaps, limit, cyc;
        bit sw, to;
        for (int i = 0; i < DEPTH; i++) stim[i] = '0;
        stim[0] = 5; stim[1] = 3; stim[2] = 5; stim[3] = 3;
        // Reference: inversion count and an early-exit bubble sort cost model.
        inv = 0;
        for (int i = 0; i < DEPTH; i++)
            for (int j = i + 1; j < DEPTH; j++)
                if (stim[i] > stim[j]) inv++;
        for (int i = 0; i < DEPTH; i++) m[i] = stim[i];
        comps = 0; swaps = 0; limit = DEPTH - 1;
        while (limit >= 1) begin
            sw = 1'b0;
            for (int i = 0; i < limit; i++) begin
                comps++;
                if (m[i] > m[i + 1]) begin
                    t = m[i]; m[i] = m[i + 1]; m[i + 1] = t;
                    swaps++; sw = 1'b1;
                end
            end
            if (!sw) break;
            limit--;
        end
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = m[i];
        load_stim();
        start_call();
        wait_idle(cyc, to);
        vectors++;
        if (to || cyc != comps + swaps + 1) begin
            $display("FAIL dup_busy got %0d cycles (timeout=%0d) want %0d", cyc, to, comps + swaps + 1);
            miscompares++;
        end
        vectors++;
        if (run_return !== 16'(inv)) begin
            $display("FAIL dup_return got %0d want %0d", run_return, inv); miscompares++;
        end
        for (int i = 0; i < DEPTH; i++) begin
            read_word(i, v);
            vectors++;
            if (v !== exp_mem[i]) begin
                $display("FAIL dup_mem[%0d] got %0d want %0d", i, v, exp_mem[i]); miscompares++;
            end
        end
    endtask

    task automatic test_protocol();
        int c1, c2, idle;
        bit to;
        logic [WIDTH-1:0] v;
        @(negedge clk);
        run_req = 1'b1;
        @(negedge clk);
        wait_idle(c1, to);
        idle = 0;
        while (run_busy !== 1'b1 && idle < 10) begin
            idle++;
            @(negedge clk);
        end
        // Second call is under way: drop the request and try to write.
        run_req = 1'b0;
        c2 = 0;
        while (run_busy === 1'b1 && c2 <= BOUND) begin
            c2++;
            data_we   = 1'b1;
            data_addr = ADDR_W'(c2);
            data_din  = 32'hDEAD_0000 + WIDTH'(c2);
            @(negedge clk);
        end
        data_we = 1'b0;
        vectors++;
        if (to || c1 != 16) begin
            $display("FAIL proto_busy1 got %0d want 16", c1); miscompares++;
        end
        vectors++;
        if (idle != 1) begin
            $display("FAIL proto_idle got %0d want 1", idle); miscompares++;
        end
        vectors++;
        if (c2 != 16) begin
            $display("FAIL proto_busy2 got %0d want 16", c2); miscompares++;
        end
        vectors++;
        if (run_return !== 16'd0) begin
            $display("FAIL proto_return got %0d want 0", run_return); miscompares++;
        end
        for (int i = 0; i < DEPTH; i++) begin
            read_word(i, v);
            vectors++;
            if (v !== exp_mem[i]) begin
                $display("FAIL proto_mem[%0d] got %0h want %0h", i, v, exp_mem[i]); miscompares++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit to;
        logic [WIDTH-1:0] v;
        for (int i = 0; i < DEPTH; i++) stim[i] = WIDTH'(DEPTH - i);
        load_stim();
        start_call();
        repeat (49) @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if (run_busy !== 1'b0 || run_return !== 16'd0 || data_dout !== '0) begin
            $display("FAIL midrst_outputs got busy=%0b ret=%0d dout=%0h want 0/0/0",
                     run_busy, run_return, data_dout);
            miscompares++;
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (run_busy !== 1'b0) begin
            $display("FAIL midrst_busy got %0b want 0", run_busy); miscompares++;
        end
        for (int i = 0; i < DEPTH; i++) begin
            read_word(i, v);
            vectors++;
            if (v !== '0) begin
                $display("FAIL midrst_mem[%0d] got %0h want 0", i, v); miscompares++;
            end
        end
        load_stim();
        start_call();
        wait_idle(cyc, to);
        vectors++;
        if (to || cyc != 241 || run_return !== 16'd120) begin
            $display("FAIL midrst_rerun got %0d cycles ret=%0d want 241/120", cyc, run_return);
            miscompares++;
        end
        for (int i = 0; i < DEPTH; i++) begin
            read_word(i, v);
            vectors++;
            if (v !== WIDTH'(i + 1)) begin
                $display("FAIL midrst_mem2[%0d] got %0d want %0d", i, v, i + 1); miscompares++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_reverse();
        test_sorted();
        test_rw_same_cycle();
        test_duplicates();
        test_protocol();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
